// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide sequential adder: FSM encoding,
// default geometry and the limb-index width helper.
package wide_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 128;
  localparam int unsigned DEF_LIMB  = 32;
  localparam int unsigned DEF_NLIMB = DEF_WIDTH / DEF_LIMB;
  localparam int unsigned DEF_IDX_W = $clog2(DEF_NLIMB);

  // Index register width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nlimb);
    return (nlimb > 1) ? $clog2(nlimb) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq_limb_add32.sv
// Combinational LIMB-bit adder built from 4-bit carry-lookahead groups;
// also exposes the carry into the top bit for overflow detection.
module limb_add32 #(
  parameter int unsigned LIMB = 32
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            cin,
  output logic [LIMB-1:0] s,
  output logic            cout,
  output logic            c_msb_in
);

  localparam int unsigned GS = 4;
  localparam int unsigned NG = (LIMB + GS - 1) / GS;

  logic [LIMB-1:0] g;
  logic [LIMB-1:0] p;
  logic [LIMB:0]   c;
  logic [NG:0]     gc;
  logic            gg;
  logic            gp;
  int unsigned     bi;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gc = '0;
    c  = '0;
    gg = 1'b0;
    gp = 1'b1;
    bi = 0;
    gc[0] = cin;
    // Group generate/propagate first, so group carries chain without per-bit ripple.
    for (int unsigned k = 0; k < NG; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int unsigned j = 0; j < GS; j++) begin
        bi = k * GS + j;
        if (bi < LIMB) begin
          gg = g[bi] | (p[bi] & gg);
          gp = gp & p[bi];
        end
      end
      gc[k+1] = gg | (gp & gc[k]);
    end
    for (int unsigned k = 0; k < NG; k++) begin
      c[k*GS] = gc[k];
      for (int unsigned j = 0; j < GS; j++) begin
        bi = k * GS + j;
        if (bi < LIMB) begin
          if ((j == GS - 1) || (bi == LIMB - 1)) begin
            c[bi+1] = gc[k+1];
          end else begin
            c[bi+1] = g[bi] | (p[bi] & c[bi]);
          end
        end
      end
    end
  end

  assign s        = p ^ c[LIMB-1:0];
  assign cout     = c[LIMB];
  assign c_msb_in = c[LIMB-1];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one LIMB-bit adder,
// one limb per cycle, with valid/ready handshakes on both sides.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LIMB  = DEF_LIMB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned IDXW  = idx_width(NLIMB);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [LIMB-1:0]  limb_a;
  logic [LIMB-1:0]  limb_b;
  logic [LIMB-1:0]  limb_s;
  logic             limb_co;
  logic             limb_cm;

  limb_add32 #(
    .LIMB(LIMB)
  ) u_limb (
    .a        (limb_a),
    .b        (limb_b),
    .cin      (carry_q),
    .s        (limb_s),
    .cout     (limb_co),
    .c_msb_in (limb_cm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    limb_a  = '0;
    limb_b  = '0;

    for (int unsigned k = 0; k < NLIMB; k++) begin
      if (idx_q == IDXW'(k)) begin
        limb_a = a_q[k*LIMB +: LIMB];
        limb_b = b_q[k*LIMB +: LIMB];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction as A + ~B + 1: invert B here, seed the carry with sub.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < NLIMB; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[k*LIMB +: LIMB] = limb_s;
          end
        end
        carry_d = limb_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDXW'(NLIMB - 1)) begin
          cout_d  = limb_co;
          ovf_d   = limb_co ^ limb_cm;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and randomized checks of wide_add_seq against hand-computed
// vectors and a (WIDTH+1)-bit reference sum.
module tb_wide_add_seq;

  localparam int W  = 128;
  localparam int L  = 32;
  localparam int NL = W / L;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int vec_cnt = 0;
  int err_cnt = 0;

  wide_add_seq #(
    .WIDTH(W),
    .LIMB (L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("ready_valid_exclusive", W'(in_ready & out_valid), '0);
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic [W-1:0] yp;
    yp = y ^ {W{s}};
    return {1'b0, x} + {1'b0, yp} + (W+1)'(s);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic [W-1:0] r);
    logic [W-1:0] yp;
    yp = y ^ {W{s}};
    return (x[W-1] == yp[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // One transaction: handshake, latency check, result check, optional stall, release.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W-1:0] e_sum, input logic e_cout,
                        input logic e_ovf, input int stall, input logic poke);
    int n;
    logic [W-1:0] held;
    in_valid = 1'b1;
    a = x;
    b = y;
    sub = s;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, ".in_ready"}, W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    sub = ~s;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, W'(n), W'(NL));
    chk({tag, ".sum"}, sum, e_sum);
    chk({tag, ".cout"}, W'(cout), W'(e_cout));
    chk({tag, ".ovf"}, W'(ovf), W'(e_ovf));
    held = sum;
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        a = {$urandom, $urandom, $urandom, $urandom};
        sub = 1'b0;
      end
      tick();
      chk({tag, ".stall_valid"}, W'(out_valid), W'(1));
      chk({tag, ".stall_sum"}, sum, held);
      if (poke) chk({tag, ".stall_in_ready"}, W'(in_ready), '0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".release_valid"}, W'(out_valid), '0);
    chk({tag, ".release_ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
    logic [W:0]   r;

    rst = 1'b1;
    in_valid = 1'b1;
    a = '1;
    b = '1;
    sub = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset.in_ready", W'(in_ready), W'(1));
    chk("reset.out_valid", W'(out_valid), '0);
    chk("reset.sum", sum, '0);
    chk("reset.cout", W'(cout), '0);
    chk("reset.ovf", W'(ovf), '0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();

    run_op("ones_plus_one", {W{1'b1}}, W'(1), 1'b0, '0, 1'b1, 1'b0, 0, 1'b0);
    run_op("maxpos_plus_one", {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0,
           {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1, 0, 1'b0);
    run_op("5_minus_7", W'(5), W'(7), 1'b1, {{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0, 0, 1'b0);
    run_op("7_minus_5", W'(7), W'(5), 1'b1, W'(2), 1'b1, 1'b0, 0, 1'b0);
    run_op("minneg_minus_one", {1'b1, {(W-1){1'b0}}}, W'(1), 1'b1,
           {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1, 0, 1'b0);
    run_op("limb_carry", W'(32'hFFFF_FFFF), W'(1), 1'b0, W'(64'h1_0000_0000), 1'b0, 1'b0, 0, 1'b0);
    run_op("stall10", W'(100), W'(23), 1'b0, W'(123), 1'b0, 1'b0, 10, 1'b1);

    // Reset on the second RUN cycle, with in_valid held high through it.
    in_valid = 1'b1;
    a = W'(9);
    b = W'(9);
    sub = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_run.in_ready", W'(in_ready), W'(1));
    chk("rst_run.out_valid", W'(out_valid), '0);
    chk("rst_run.sum", sum, '0);
    chk("rst_run.cout", W'(cout), '0);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_run.no_pulse", W'(out_valid), '0);
    end
    run_op("after_rst_3_plus_4", W'(3), W'(4), 1'b0, W'(7), 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) y = ~x;
      s = 1'($urandom_range(0, 1));
      r = ref_add(x, y, s);
      run_op("random", x, y, s, r[W-1:0], r[W], ref_ovf(x, y, s, r[W-1:0]),
             int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
